// File: rtl/i2s_tx.sv
// ============================================================================
// Module   : i2s_tx
// Purpose  : I2S transmitter. Accepts stereo sample pairs into a single-entry
//            holding register over a valid/ready handshake, divides baseclk
//            down to bclk, and shifts each channel out MSB-first in standard
//            I2S framing (lrck leads the MSB by one bclk period). Slots are
//            zero-padded after the LSB. A frame that starts while the holding
//            register is empty is sent as silence and reported as an underrun.
// Ports    : baseclk      - system clock, all flops
//            reset_pre1   - asynchronous reset, active low
//            enable       - 1 = run serial clocks, 0 = hold outputs idle
//            s_valid      - sample pair valid
//            s_ready      - holding register empty
//            s_left       - left sample (two's complement)
//            s_right      - right sample (two's complement)
//            bclk         - I2S bit clock
//            lrck         - word select, 0 = left, 1 = right
//            sdata        - serial data, changes with bclk falling
//            underrun     - one-cycle pulse, frame started with no data
//            underrun_cnt - saturating underrun count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_tx #(
  parameter int BCLK_DIV = 4,   // baseclk cycles per bclk half-period
  parameter int SAMPLE_W = 16,  // bits per channel sample
  parameter int SLOT_W   = 32   // bclk periods per channel slot
) (
  input  logic                baseclk,
  input  logic                reset_pre1,
  input  logic                enable,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                bclk,
  output logic                lrck,
  output logic                sdata,
  output logic                underrun,
  output logic [7:0]          underrun_cnt
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] LRCK_LO  = BIT_W'(SLOT_W - 1);
  localparam logic [BIT_W-1:0] LRCK_HI  = BIT_W'(2 * SLOT_W - 2);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [SAMPLE_W-1:0] hold_left;
  logic [SAMPLE_W-1:0] hold_right;
  logic [SAMPLE_W-1:0] shadow_left;
  logic [SAMPLE_W-1:0] shadow_right;

  // --------------------------------------------------------------------------
  // Next-state helpers
  // --------------------------------------------------------------------------
  logic                div_wrap;
  logic                fall_event;
  logic                frame_load;
  logic [BIT_W-1:0]    bit_next;
  logic [SAMPLE_W-1:0] shadow_left_next;
  logic [SAMPLE_W-1:0] shadow_right_next;
  logic                lrck_next;
  logic                sdata_next;

  assign div_wrap   = (div_cnt == DIV_LAST);
  // bclk is about to toggle 1->0: this edge starts a new bit period.
  assign fall_event = enable && div_wrap && bclk;
  assign bit_next   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
  assign frame_load = fall_event && (bit_next == '0);

  // The MSB of the left word goes out on the very edge that loads the shadow,
  // so serialization works from the value the shadow is about to take.
  // An empty holding register (s_ready=1) at load time means silence.
  always_comb begin
    shadow_left_next  = shadow_left;
    shadow_right_next = shadow_right;
    if (frame_load) begin
      shadow_left_next  = s_ready ? '0 : hold_left;
      shadow_right_next = s_ready ? '0 : hold_right;
    end
  end

  // Word select switches one bit period ahead of each channel's MSB.
  assign lrck_next = (bit_next >= LRCK_LO) && (bit_next <= LRCK_HI);

  // Bit position b carries left[SAMPLE_W-1-b] in the left slot and
  // right[SAMPLE_W-1-(b-SLOT_W)] in the right slot; padding bits are zero.
  always_comb begin
    sdata_next = 1'b0;
    for (int i = 0; i < SAMPLE_W; i++) begin
      if (bit_next == BIT_W'(SAMPLE_W - 1 - i)) begin
        sdata_next = shadow_left_next[i];
      end
      if (bit_next == BIT_W'(SLOT_W + SAMPLE_W - 1 - i)) begin
        sdata_next = shadow_right_next[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Serial clock generation, framing and sample buffering
  // --------------------------------------------------------------------------
  always_ff @(posedge baseclk or negedge reset_pre1) begin
    if (!reset_pre1) begin
      div_cnt      <= '0;
      bit_cnt      <= BIT_LAST;
      bclk         <= 1'b0;
      lrck         <= 1'b0;
      sdata        <= 1'b0;
      s_ready      <= 1'b1;
      underrun     <= 1'b0;
      underrun_cnt <= 8'd0;
      hold_left    <= '0;
      hold_right   <= '0;
      shadow_left  <= '0;
      shadow_right <= '0;
    end else begin
      underrun <= 1'b0;

      if (enable) begin
        if (div_wrap) begin
          div_cnt <= '0;
          bclk    <= ~bclk;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
        if (fall_event) begin
          bit_cnt <= bit_next;
          lrck    <= lrck_next;
          sdata   <= sdata_next;
        end
      end else begin
        // Park at the end of a frame so re-enabling begins with a fresh load.
        div_cnt <= '0;
        bit_cnt <= BIT_LAST;
        bclk    <= 1'b0;
        lrck    <= 1'b0;
        sdata   <= 1'b0;
      end

      if (frame_load) begin
        shadow_left  <= shadow_left_next;
        shadow_right <= shadow_right_next;
        if (s_ready) begin
          underrun <= 1'b1;
          if (underrun_cnt != 8'hFF) begin
            underrun_cnt <= underrun_cnt + 8'd1;
          end
        end
      end

      // A load only drains a full register and a transfer only fills an empty
      // one, so the two never act together. A transfer coinciding with a load
      // of an empty register lands in holding for the following frame.
      if (!s_ready) begin
        if (frame_load) begin
          s_ready <= 1'b1;
        end
      end else if (s_valid) begin
        hold_left  <= s_left;
        hold_right <= s_right;
        s_ready    <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
